// File: rtl/ahb_subordinate_mem_if.sv
// ---------------------------------------------------------------------------
// ahb_subordinate_mem_if
// AHB5 bus bundle between a manager/interconnect and the subordinate memory.
//   master modport : drives address/control/write data and the combined HREADY,
//                    observes HRDATA/HREADYOUT/HRESP/HEXOKAY
//   slave modport  : the reverse view, used by ahb_subordinate_mem
// ---------------------------------------------------------------------------
interface ahb_subordinate_mem_if #(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned HMASTER_WIDTH = 4
) ();
  logic                       HSEL;
  logic [ADDR_WIDTH-1:0]      HADDR;
  logic [1:0]                 HTRANS;
  logic                       HWRITE;
  logic [2:0]                 HSIZE;
  logic [2:0]                 HBURST;
  logic                       HEXCL;
  logic [HMASTER_WIDTH-1:0]   HMASTER;
  logic [DATA_WIDTH-1:0]      HWDATA;
  logic [DATA_WIDTH/8-1:0]    HWSTRB;
  logic                       HREADY;
  logic [DATA_WIDTH-1:0]      HRDATA;
  logic                       HREADYOUT;
  logic                       HRESP;
  logic                       HEXOKAY;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HEXCL, HMASTER,
    output HWDATA, HWSTRB, HREADY,
    input  HRDATA, HREADYOUT, HRESP, HEXOKAY
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HEXCL, HMASTER,
    input  HWDATA, HWSTRB, HREADY,
    output HRDATA, HREADYOUT, HRESP, HEXOKAY
  );
endinterface

// File: rtl/ahb_subordinate_mem.sv
// ---------------------------------------------------------------------------
// ahb_subordinate_mem
// AHB5 subordinate memory model with programmable wait states, byte-strobe
// writes, two-cycle ERROR responses and a per-manager exclusive monitor.
// Ports:
//   HCLK    : bus clock, all state updates on the rising edge
//   HRESETn : asynchronous active-low reset (memory array is not cleared)
//   bus     : ahb_subordinate_mem_if.slave (address/control/data in,
//             HRDATA/HREADYOUT/HRESP/HEXOKAY out, all outputs registered)
// ---------------------------------------------------------------------------
module ahb_subordinate_mem #(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned MEM_DEPTH     = 1024,
  parameter int unsigned BASE_ADDR     = 0,
  parameter int unsigned WAIT_STATES   = 0,
  parameter int unsigned HMASTER_WIDTH = 4,
  parameter int unsigned NUM_MASTERS   = 4
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  ahb_subordinate_mem_if.slave  bus
);

  localparam int unsigned BW    = DATA_WIDTH / 8;
  localparam int unsigned LB    = $clog2(BW);
  localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam longint unsigned SPAN = longint'(MEM_DEPTH) * longint'(BW);
  localparam logic [ADDR_WIDTH-1:0] BASE_L = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  // Byte lanes touched by a transfer of 2**size bytes at byte offset off.
  function automatic logic [BW-1:0] lane_mask(input logic [2:0] size,
                                               input logic [LB-1:0] off);
    logic [BW-1:0] m;
    case (size)
      3'd0:    m = BW'(8'h01);
      3'd1:    m = BW'(8'h03);
      3'd2:    m = BW'(8'h0F);
      3'd3:    m = BW'(8'hFF);
      default: m = '0;
    endcase
    return m << off;
  endfunction

  // Replace the enabled bytes of old_w with those of new_w.
  function automatic logic [DATA_WIDTH-1:0] merge_bytes(input logic [DATA_WIDTH-1:0] old_w,
                                                        input logic [DATA_WIDTH-1:0] new_w,
                                                        input logic [BW-1:0]         en);
    logic [DATA_WIDTH-1:0] r;
    r = old_w;
    for (int b = 0; b < int'(BW); b++) begin
      if (en[b]) begin
        r[8*b +: 8] = new_w[8*b +: 8];
      end else begin
        r[8*b +: 8] = old_w[8*b +: 8];
      end
    end
    return r;
  endfunction

  // Storage
  logic [DATA_WIDTH-1:0] mem_r [MEM_DEPTH];

  // FSM and registered outputs
  state_t                state_r, state_n;
  logic [3:0]            cnt_r, cnt_n;
  logic                  hreadyout_r, hresp_r, hexokay_r;
  logic [DATA_WIDTH-1:0] hrdata_r;
  logic                  hready_n, hresp_n, hexok_n;
  logic [DATA_WIDTH-1:0] hrdata_n;
  logic                  take_s, fin_s;

  // Transfer held across wait states
  logic                     cap_write_r, cap_excl_r;
  logic [HMASTER_WIDTH-1:0] cap_master_r;
  logic [IDX_W-1:0]         cap_idx_r;
  logic [BW-1:0]            cap_mask_r;

  // Transfer whose final data-phase cycle is the current cycle
  logic                  dp_valid_r, dp_write_r, dp_wr_ok_r;
  logic [IDX_W-1:0]      dp_idx_r;
  logic [BW-1:0]         dp_mask_r;

  // Exclusive monitor
  logic [NUM_MASTERS-1:0] resv_valid_r;
  logic [IDX_W-1:0]       resv_idx_r [NUM_MASTERS];

  // Address-phase decode
  logic                  acc_s, in_range_s, size_err_s, align_err_s, err_s;
  logic [ADDR_WIDTH-1:0] off_s;
  logic [2:0]            amask_s;
  logic [IDX_W-1:0]      a_idx_s;
  logic [BW-1:0]         a_mask_s;

  // Fields of the transfer entering its final cycle
  logic                     f_write_s, f_excl_s;
  logic [HMASTER_WIDTH-1:0] f_master_s;
  logic [IDX_W-1:0]         f_idx_s;
  logic [BW-1:0]            f_mask_s;
  logic                     master_ok_s, resv_match_s, excl_hit_s, resv_set_s;

  logic                  commit_s;
  logic [DATA_WIDTH-1:0] wr_word_s, rd_word_s;
  logic                  unused_s;

  assign unused_s = ^{bus.HBURST, bus.HTRANS[0]};

  assign acc_s       = bus.HSEL & bus.HREADY & bus.HTRANS[1];
  assign off_s       = bus.HADDR - BASE_L;
  assign in_range_s  = (bus.HADDR >= BASE_L) && (64'(off_s) < SPAN);
  assign size_err_s  = (bus.HSIZE > 3'(LB));
  assign align_err_s = |(bus.HADDR[2:0] & amask_s);
  assign err_s       = !in_range_s || size_err_s || align_err_s;
  assign a_idx_s     = off_s[LB +: IDX_W];
  assign a_mask_s    = lane_mask(bus.HSIZE, bus.HADDR[LB-1:0]);

  // Low address bits that must be zero for the requested size.
  always_comb begin
    amask_s = 3'b111;
    case (bus.HSIZE)
      3'd0:    amask_s = 3'b000;
      3'd1:    amask_s = 3'b001;
      3'd2:    amask_s = 3'b011;
      3'd3:    amask_s = 3'b111;
      default: amask_s = 3'b111;
    endcase
  end

  // Next-state logic: acceptance, wait countdown and the two-cycle error.
  always_comb begin
    state_n  = state_r;
    cnt_n    = cnt_r;
    take_s   = 1'b0;
    fin_s    = 1'b0;
    hready_n = 1'b1;
    hresp_n  = 1'b0;
    case (state_r)
      // ST_ERR2 is a final (ready) cycle, so it overlaps a new address phase.
      ST_IDLE, ST_ERR2: begin
        if (acc_s) begin
          take_s = 1'b1;
          if (err_s) begin
            state_n  = ST_ERR1;
            hready_n = 1'b0;
            hresp_n  = 1'b1;
          end else if (WAIT_STATES > 0) begin
            state_n  = ST_WAIT;
            cnt_n    = 4'(WAIT_STATES - 1);
            hready_n = 1'b0;
          end else begin
            state_n = ST_IDLE;
            fin_s   = 1'b1;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_n = ST_IDLE;
          fin_s   = 1'b1;
        end else begin
          cnt_n    = cnt_r - 4'd1;
          hready_n = 1'b0;
        end
      end
      ST_ERR1: begin
        state_n = ST_ERR2;
        hresp_n = 1'b1;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Final-cycle fields come from the live bus without wait states, else from the capture.
  always_comb begin
    if (state_r == ST_WAIT) begin
      f_write_s  = cap_write_r;
      f_excl_s   = cap_excl_r;
      f_master_s = cap_master_r;
      f_idx_s    = cap_idx_r;
      f_mask_s   = cap_mask_r;
    end else begin
      f_write_s  = bus.HWRITE;
      f_excl_s   = bus.HEXCL;
      f_master_s = bus.HMASTER;
      f_idx_s    = a_idx_s;
      f_mask_s   = a_mask_s;
    end
  end

  // Write path: commits on the last edge of an OKAY write data phase.
  assign commit_s  = dp_valid_r & dp_write_r & dp_wr_ok_r;
  assign wr_word_s = merge_bytes(mem_r[dp_idx_r], bus.HWDATA, dp_mask_r & bus.HWSTRB);
  // Forward a write committing on this edge so a following read sees it.
  assign rd_word_s = (commit_s && (dp_idx_r == f_idx_s)) ? wr_word_s : mem_r[f_idx_s];

  // Exclusive monitor lookup for the transfer entering its final cycle.
  always_comb begin
    master_ok_s  = 1'b0;
    resv_match_s = 1'b0;
    for (int i = 0; i < int'(NUM_MASTERS); i++) begin
      if (f_master_s == HMASTER_WIDTH'(i)) begin
        master_ok_s = 1'b1;
        if (resv_valid_r[i] && (resv_idx_r[i] == f_idx_s)) begin
          resv_match_s = 1'b1;
        end else begin
          resv_match_s = resv_match_s;
        end
      end else begin
        master_ok_s = master_ok_s;
      end
    end
    // A write committing to the same word on this edge kills the reservation.
    excl_hit_s = resv_match_s && !(commit_s && (dp_idx_r == f_idx_s));
    resv_set_s = fin_s && f_excl_s && !f_write_s && master_ok_s;
  end

  // Output values for the next cycle.
  always_comb begin
    hexok_n  = 1'b0;
    hrdata_n = '0;
    if (fin_s) begin
      if (f_write_s) begin
        hexok_n = f_excl_s && excl_hit_s;
      end else begin
        hexok_n  = f_excl_s && master_ok_s;
        hrdata_n = rd_word_s;
      end
    end else begin
      hexok_n  = 1'b0;
      hrdata_n = '0;
    end
  end

  // State, outputs and final-cycle transfer registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      hreadyout_r <= 1'b1;
      hresp_r     <= 1'b0;
      hexokay_r   <= 1'b0;
      hrdata_r    <= '0;
      dp_valid_r  <= 1'b0;
      dp_write_r  <= 1'b0;
      dp_wr_ok_r  <= 1'b0;
      dp_idx_r    <= '0;
      dp_mask_r   <= '0;
    end else begin
      state_r     <= state_n;
      cnt_r       <= cnt_n;
      hreadyout_r <= hready_n;
      hresp_r     <= hresp_n;
      hexokay_r   <= hexok_n;
      hrdata_r    <= hrdata_n;
      dp_valid_r  <= fin_s;
      if (fin_s) begin
        dp_write_r <= f_write_s;
        dp_wr_ok_r <= !f_excl_s || excl_hit_s;
        dp_idx_r   <= f_idx_s;
        dp_mask_r  <= f_mask_s;
      end
    end
  end

  // Capture of accepted control for transfers that go through wait states.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cap_write_r  <= 1'b0;
      cap_excl_r   <= 1'b0;
      cap_master_r <= '0;
      cap_idx_r    <= '0;
      cap_mask_r   <= '0;
    end else if (take_s) begin
      cap_write_r  <= bus.HWRITE;
      cap_excl_r   <= bus.HEXCL;
      cap_master_r <= bus.HMASTER;
      cap_idx_r    <= a_idx_s;
      cap_mask_r   <= a_mask_s;
    end
  end

  // Reservations: set by exclusive reads, cleared by any write to the same word.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      resv_valid_r <= '0;
      for (int i = 0; i < int'(NUM_MASTERS); i++) begin
        resv_idx_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NUM_MASTERS); i++) begin
        if (resv_set_s && (f_master_s == HMASTER_WIDTH'(i))) begin
          resv_valid_r[i] <= 1'b1;
          resv_idx_r[i]   <= f_idx_s;
        end else if (commit_s && resv_valid_r[i] && (resv_idx_r[i] == dp_idx_r)) begin
          resv_valid_r[i] <= 1'b0;
        end
      end
    end
  end

  // Memory array write port; contents survive reset.
  always_ff @(posedge HCLK) begin
    if (commit_s) begin
      mem_r[dp_idx_r] <= wr_word_s;
    end
  end

  assign bus.HREADYOUT = hreadyout_r;
  assign bus.HRESP     = hresp_r;
  assign bus.HEXOKAY   = hexokay_r;
  assign bus.HRDATA    = hrdata_r;

endmodule

// File: tb/tb_ahb_subordinate_mem.sv
// ---------------------------------------------------------------------------
// tb_ahb_subordinate_mem
// Two memories share one set of bus drivers: dut0 (no wait states) and dut3
// (three wait states); 'tgt' selects which one gets HSEL and returns HREADY.
// Expected responses are pushed to a scoreboard queue at address acceptance
// and compared when the data phase completes.
// ---------------------------------------------------------------------------
module tb_ahb_subordinate_mem;

  logic clk, rst_n;
  logic tgt;

  logic        hsel, hwrite, hexcl;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hmaster, hwstrb;
  logic        hready, hresp_s, hexok_s;
  logic [31:0] hrdata_s;

  ahb_subordinate_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .HMASTER_WIDTH(4)) if0 ();
  ahb_subordinate_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .HMASTER_WIDTH(4)) if3 ();

  assign if0.HSEL = hsel & ~tgt;
  assign if3.HSEL = hsel & tgt;
  assign {if0.HADDR, if0.HTRANS, if0.HWRITE, if0.HSIZE, if0.HBURST} = {haddr, htrans, hwrite, hsize, hburst};
  assign {if3.HADDR, if3.HTRANS, if3.HWRITE, if3.HSIZE, if3.HBURST} = {haddr, htrans, hwrite, hsize, hburst};
  assign {if0.HEXCL, if0.HMASTER, if0.HWDATA, if0.HWSTRB} = {hexcl, hmaster, hwdata, hwstrb};
  assign {if3.HEXCL, if3.HMASTER, if3.HWDATA, if3.HWSTRB} = {hexcl, hmaster, hwdata, hwstrb};
  assign hready     = tgt ? if3.HREADYOUT : if0.HREADYOUT;
  assign if0.HREADY = hready;
  assign if3.HREADY = hready;
  assign hresp_s    = tgt ? if3.HRESP   : if0.HRESP;
  assign hexok_s    = tgt ? if3.HEXOKAY : if0.HEXOKAY;
  assign hrdata_s   = tgt ? if3.HRDATA  : if0.HRDATA;

  ahb_subordinate_mem #(.WAIT_STATES(0)) dut0 (.HCLK(clk), .HRESETn(rst_n), .bus(if0));
  ahb_subordinate_mem #(.WAIT_STATES(3)) dut3 (.HCLK(clk), .HRESETn(rst_n), .bus(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    bit          err;
    bit          exok;
    int          waits;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] ref_mem [logic [31:0]];
  int          lo_cnt = 0;

  function automatic logic [31:0] rkey(input logic [31:0] a);
    return {tgt, 1'b0, a[31:2]};
  endfunction

  // Data-phase monitor: counts low cycles and compares at completion.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && sb_q.size() > 0) begin
      if (!hready) begin
        lo_cnt++;
        check_val({sb_q[0].tag, "/resp_lo"}, 32'(hresp_s), 32'(sb_q[0].err));
        if (lo_cnt > 40) begin
          check_val({sb_q[0].tag, "/wait_bound"}, 32'(lo_cnt), 32'd40);
          void'(sb_q.pop_front());
          lo_cnt = 0;
        end
      end else begin
        e = sb_q.pop_front();
        check_val({e.tag, "/waits"}, 32'(lo_cnt), 32'(e.waits));
        check_val({e.tag, "/rdata"}, hrdata_s, e.rdata);
        check_val({e.tag, "/resp"},  32'(hresp_s), 32'(e.err));
        check_val({e.tag, "/exokay"}, 32'(hexok_s), 32'(e.exok));
        lo_cnt = 0;
      end
    end
  end

  task automatic xfer(input string tag, input bit wr, input logic [31:0] addr,
                      input logic [2:0] size, input bit excl, input logic [3:0] mst,
                      input logic [31:0] wdata, input logic [3:0] strb,
                      input bit exp_err, input bit exp_exok);
    exp_t        e;
    int          guard;
    logic [31:0] cur;
    int          lo, nb;
    hsel = 1'b1; haddr = addr; htrans = 2'b10; hwrite = wr; hsize = size;
    hexcl = excl; hmaster = mst; hburst = 3'b000;
    guard = 0;
    @(negedge clk);
    while (!hready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (!hready) check_val({tag, "/accept"}, 32'(hready), 32'd1);
    @(posedge clk);
    #1;
    hwdata = wdata; hwstrb = strb; hsel = 1'b0; htrans = 2'b00; hexcl = 1'b0;
    e.tag   = tag;
    e.err   = exp_err;
    e.exok  = exp_exok;
    e.waits = exp_err ? 1 : (tgt ? 3 : 0);
    cur = ref_mem.exists(rkey(addr)) ? ref_mem[rkey(addr)] : 32'h0;
    e.rdata = (exp_err || wr) ? 32'h0 : cur;
    if (wr && !exp_err && (!excl || exp_exok)) begin
      lo = int'(addr[1:0]);
      nb = 1 << size;
      for (int b = 0; b < 4; b++) begin
        if (b >= lo && b < lo + nb && strb[b]) cur[8*b +: 8] = wdata[8*b +: 8];
      end
      ref_mem[rkey(addr)] = cur;
    end
    sb_q.push_back(e);
  endtask

  task automatic wr32(input string tag, input logic [31:0] a, input logic [31:0] d);
    xfer(tag, 1'b1, a, 3'd2, 1'b0, 4'd0, d, 4'hF, 1'b0, 1'b0);
  endtask

  task automatic rd32(input string tag, input logic [31:0] a);
    xfer(tag, 1'b0, a, 3'd2, 1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic go_idle();
    int guard;
    hsel = 1'b0; htrans = 2'b00; hexcl = 1'b0;
    guard = 0;
    while (sb_q.size() > 0 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    if (sb_q.size() > 0) begin
      check_val("idle_drain", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    logic [2:0]  sz;
    logic [1:0]  off;
    tgt = 1'b0; hsel = 1'b0; haddr = 32'h0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'd2; hburst = 3'd0; hexcl = 1'b0; hmaster = 4'd0;
    hwdata = 32'h0; hwstrb = 4'h0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst0_hreadyout", 32'(if0.HREADYOUT), 32'd1);
    check_val("rst0_hresp",     32'(if0.HRESP),     32'd0);
    check_val("rst3_hexokay",   32'(if3.HEXOKAY),   32'd0);
    check_val("rst3_hrdata",    if3.HRDATA,         32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back write then read, zero wait states
    wr32("t1_wr", 32'h10, 32'hDEADBEEF);
    rd32("t1_rd", 32'h10);
    go_idle();

    // Byte write inside a word, strobes outside the lane ignored
    wr32("t3_wr", 32'h10, 32'h11223344);
    xfer("t3_byte", 1'b1, 32'h13, 3'd0, 1'b0, 4'd0, 32'hAA000000, 4'hF, 1'b0, 1'b0);
    rd32("t3_rd", 32'h10);
    xfer("t3_half", 1'b1, 32'h12, 3'd1, 1'b0, 4'd0, 32'h55667788, 4'h7, 1'b0, 1'b0);
    rd32("t3_rd2", 32'h10);
    go_idle();

    // Errors: out of range, misaligned halfword, oversize
    wr32("t4_init", 32'h0, 32'hCAFEF00D);
    xfer("t4_range", 1'b0, 32'h1000, 3'd2, 1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 1'b0);
    xfer("t4_align", 1'b1, 32'h01, 3'd1, 1'b0, 4'd0, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b0);
    xfer("t4_size",  1'b1, 32'h00, 3'd3, 1'b0, 4'd0, 32'h0, 4'hF, 1'b1, 1'b0);
    xfer("t4_below_span", 1'b0, 32'hFFC, 3'd2, 1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 1'b0);
    rd32("t4_rd", 32'h0);
    go_idle();

    // Exclusive monitor
    wr32("t5_init", 32'h40, 32'h0BADC0DE);
    xfer("t5_xrd",  1'b0, 32'h40, 3'd2, 1'b1, 4'd1, 32'h0, 4'h0, 1'b0, 1'b1);
    xfer("t5_m2wr", 1'b1, 32'h40, 3'd2, 1'b0, 4'd2, 32'h22222222, 4'hF, 1'b0, 1'b0);
    xfer("t5_xwr_fail", 1'b1, 32'h40, 3'd2, 1'b1, 4'd1, 32'h11111111, 4'hF, 1'b0, 1'b0);
    rd32("t5_rd1", 32'h40);
    xfer("t5_xrd2", 1'b0, 32'h40, 3'd2, 1'b1, 4'd1, 32'h0, 4'h0, 1'b0, 1'b1);
    xfer("t5_xwr_ok", 1'b1, 32'h40, 3'd2, 1'b1, 4'd1, 32'h33333333, 4'hF, 1'b0, 1'b1);
    rd32("t5_rd2", 32'h40);
    xfer("t5_m5_xrd", 1'b0, 32'h40, 3'd2, 1'b1, 4'd5, 32'h0, 4'h0, 1'b0, 1'b0);
    xfer("t5_m5_xwr", 1'b1, 32'h40, 3'd2, 1'b1, 4'd5, 32'h44444444, 4'hF, 1'b0, 1'b0);
    xfer("t5_xwr_norsv", 1'b1, 32'h40, 3'd2, 1'b1, 4'd3, 32'h55555555, 4'hF, 1'b0, 1'b0);
    rd32("t5_rd3", 32'h40);
    go_idle();

    // Random sized/strobed traffic over a prefilled window
    for (int i = 0; i < 16; i++) wr32("rnd_fill", 32'h100 + 32'(i * 4), $urandom);
    for (int i = 0; i < 40; i++) begin
      sz  = 3'($urandom_range(0, 2));
      off = 2'($urandom_range(0, 3));
      if (sz == 3'd1) off[0] = 1'b0;
      if (sz == 3'd2) off = 2'b00;
      a = 32'h100 + 32'($urandom_range(0, 15) * 4) + 32'(off);
      d = $urandom;
      xfer("rnd", 1'($urandom_range(0, 1)), a, sz, 1'b0, 4'd0, d, 4'($urandom), 1'b0, 1'b0);
    end
    go_idle();

    // Wait states on dut3
    tgt = 1'b1;
    wr32("t2_wr", 32'h80, 32'h5A5A5A5A);
    rd32("t2_rd", 32'h80);
    wr32("t2_init40", 32'h40, 32'h12345678);
    xfer("t2_xrd", 1'b0, 32'h40, 3'd2, 1'b1, 4'd1, 32'h0, 4'h0, 1'b0, 1'b1);
    xfer("t2_err", 1'b0, 32'h2000, 3'd2, 1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 1'b0);
    go_idle();

    // Reset in the middle of a waited write
    hsel = 1'b1; haddr = 32'h80; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
    hexcl = 1'b0; hmaster = 4'd0;
    @(negedge clk);
    @(posedge clk);
    #1;
    hwdata = 32'hFFFFFFFF; hwstrb = 4'hF; hsel = 1'b0; htrans = 2'b00;
    @(negedge clk);
    check_val("t6_in_wait", 32'(if3.HREADYOUT), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("t6_hreadyout", 32'(if3.HREADYOUT), 32'd1);
    check_val("t6_hresp",     32'(if3.HRESP),     32'd0);
    check_val("t6_hexokay",   32'(if3.HEXOKAY),   32'd0);
    check_val("t6_hrdata",    if3.HRDATA,         32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    xfer("t6_xwr", 1'b1, 32'h40, 3'd2, 1'b1, 4'd1, 32'h99999999, 4'hF, 1'b0, 1'b0);
    rd32("t6_rd40", 32'h40);
    rd32("t6_rd80", 32'h80);
    go_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
